// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
//
// Accepts one bundle from execute when idle. Non-memory ops go straight to
// writeback one cycle later. Memory ops are size-decoded from the opcode
// and checked for alignment. Misaligned ops produce an addr_err pulse and a
// non-writing writeback bundle. Aligned ops run a request / address-ok /
// data-ok transaction on the data SRAM port, with loads sign- or
// zero-extended.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   exe_valid ..pc_in   bundle from execute (address/result, store data, control)
//   mem_stall           registered busy flag; upstream holds while high
//   data_*              data SRAM request/response interface
//   addr_err            one-cycle misalignment pulse
//   wb_*                registered writeback bundle, wb_valid is a 1-cycle pulse
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exe_valid,
  input  logic [31:0]       alu_result,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [4:0]        write_reg_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [31:0]       inst_in,
  input  logic [31:0]       pc_in,
  output logic              mem_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              addr_err,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_result,
  output logic [4:0]        wb_write_reg,
  output logic              wb_reg_write,
  output logic [31:0]       wb_pc,
  output logic [31:0]       wb_inst
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state, state_next;

  // Context of the in-flight access needed at completion time.
  logic [31:0] alu_r;
  logic        reg_write_r;
  logic        mem_to_reg_r;
  logic        load_unsigned_r;

  logic              acc_mem;
  logic [1:0]        acc_size;
  logic              acc_unsigned;
  logic              acc_misaligned;
  logic [DATA_W-1:0] acc_wdata;
  logic [3:0]        acc_wstrb;
  logic [DATA_W-1:0] load_value;

  // Access size from opcode: 0 = byte, 1 = half, 2 = word (also the fallback).
  function automatic logic [1:0] decode_size(input logic [5:0] op);
    logic [1:0] sz;
    case (op)
      6'b100000, 6'b100100, 6'b101000: sz = 2'd0;
      6'b100001, 6'b100101, 6'b101001: sz = 2'd1;
      default:                         sz = 2'd2;
    endcase
    return sz;
  endfunction

  // Replicate store data so the addressed lane carries it regardless of offset.
  function automatic logic [DATA_W-1:0] store_lanes(input logic [1:0] sz,
                                                    input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] w;
    case (sz)
      2'd0:    w = {4{d[7:0]}};
      2'd1:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] sz,
                                              input logic [1:0] lo);
    logic [3:0] s;
    case (sz)
      2'd0:    s = 4'b0001 << lo;
      2'd1:    s = 4'b0011 << lo;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [DATA_W-1:0] load_extend(input logic [1:0] sz,
                                                    input logic uns,
                                                    input logic [1:0] lo,
                                                    input logic [DATA_W-1:0] rd);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = rd[{lo, 3'b000} +: 8];
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'd0:    r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'd1:    r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Decode the incoming bundle and compute the next FSM state.
  always_comb begin
    acc_mem        = mem_read_in | mem_write_in;
    acc_size       = decode_size(inst_in[31:26]);
    acc_unsigned   = (inst_in[31:26] == 6'b100100) || (inst_in[31:26] == 6'b100101);
    acc_misaligned = ((acc_size == 2'd1) && alu_result[0]) ||
                     ((acc_size == 2'd2) && (alu_result[1:0] != 2'b00));
    acc_wdata      = store_lanes(acc_size, mem_data_in);
    acc_wstrb      = store_strobe(acc_size, alu_result[1:0]);
    load_value     = load_extend(data_size, load_unsigned_r, data_addr[1:0], data_rdata);

    state_next = state;
    case (state)
      IDLE: begin
        if (exe_valid && acc_mem && !acc_misaligned) begin
          state_next = REQ;
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (data_addr_ok) begin
          state_next = WAIT;
        end else begin
          state_next = REQ;
        end
      end
      WAIT: begin
        if (data_data_ok) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered request, error and writeback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_stall       <= 1'b0;
      data_req        <= 1'b0;
      data_wr         <= 1'b0;
      data_size       <= 2'd0;
      data_addr       <= {ADDR_W{1'b0}};
      data_wdata      <= {DATA_W{1'b0}};
      data_wstrb      <= 4'b0000;
      addr_err        <= 1'b0;
      wb_valid        <= 1'b0;
      wb_result       <= {DATA_W{1'b0}};
      wb_write_reg    <= 5'd0;
      wb_reg_write    <= 1'b0;
      wb_pc           <= 32'h0;
      wb_inst         <= 32'h0;
      alu_r           <= 32'h0;
      reg_write_r     <= 1'b0;
      mem_to_reg_r    <= 1'b0;
      load_unsigned_r <= 1'b0;
    end else begin
      mem_stall <= (state_next != IDLE);
      wb_valid  <= 1'b0;
      addr_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (exe_valid) begin
            // Identity fields are qualified by wb_valid, so load them on accept.
            wb_write_reg    <= write_reg_in;
            wb_pc           <= pc_in;
            wb_inst         <= inst_in;
            alu_r           <= alu_result;
            reg_write_r     <= reg_write_in;
            mem_to_reg_r    <= mem_to_reg_in;
            load_unsigned_r <= acc_unsigned;
            if (!acc_mem) begin
              wb_valid     <= 1'b1;
              wb_result    <= alu_result;
              wb_reg_write <= reg_write_in;
            end else if (acc_misaligned) begin
              addr_err     <= 1'b1;
              wb_valid     <= 1'b1;
              wb_result    <= alu_result;
              wb_reg_write <= 1'b0;
            end else begin
              data_req   <= 1'b1;
              data_wr    <= mem_write_in;
              data_size  <= acc_size;
              data_addr  <= alu_result[ADDR_W-1:0];
              data_wdata <= mem_write_in ? acc_wdata : {DATA_W{1'b0}};
              data_wstrb <= mem_write_in ? acc_wstrb : 4'b0000;
            end
          end
        end
        REQ: begin
          if (data_addr_ok) begin
            data_req <= 1'b0;
          end
        end
        WAIT: begin
          if (data_data_ok) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= reg_write_r & ~data_wr;
            wb_result    <= (!data_wr && mem_to_reg_r) ? load_value : alu_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
